// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D unified-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arbState_t;

  localparam bit GNT_I       = 1'b0;
  localparam bit GNT_D       = 1'b1;
  localparam int MEM_LAT_MAX = 4;

  // Reload value for the latency counter; out-of-range latencies are clamped.
  function automatic logic [2:0] latCnt(input int lat);
    if (lat < 1)           return 3'd0;
    if (lat > MEM_LAT_MAX) return 3'(MEM_LAT_MAX - 1);
    return 3'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side (I/D) and memory-side bus bundle for mem_arbiter.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, on conflict the one not served last wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req[GNT_I] && req[GNT_D]) begin
      gnt[GNT_I] = (last == GNT_D);
      gnt[GNT_D] = (last == GNT_I);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (I) and data (D) ports onto one single-port memory
// with a fixed read latency; returns registered data plus a one-cycle ready.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0] LAT_CNT = latCnt(MEM_LAT);

  arbState_t     state;
  logic [2:0]    cnt;
  logic          lastGnt;
  logic          iReady, dReady;
  logic [DW-1:0] iRdata, dRdata;
  logic [1:0]    req, gnt;
  logic          idleOk;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;

  // A port is not eligible in the cycle its own ready pulse is high; no strobe during reset.
  assign idleOk     = (state == ARB_IDLE) & rst;
  assign req[GNT_I] = bus.i_req & ~iReady & idleOk;
  assign req[GNT_D] = bus.d_req & ~dReady & idleOk;

  rr_pick2 uPick (
    .req  (req),
    .last (lastGnt),
    .gnt  (gnt)
  );

  always_comb begin
    memWe    = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    if (gnt[GNT_I]) begin
      memAddr = bus.i_addr;
    end else if (gnt[GNT_D]) begin
      memWe    = bus.d_we;
      memAddr  = bus.d_addr;
      memWdata = bus.d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB_IDLE;
      cnt     <= 3'd0;
      lastGnt <= GNT_I;
      iReady  <= 1'b0;
      dReady  <= 1'b0;
      iRdata  <= '0;
      dRdata  <= '0;
    end else begin
      iReady <= 1'b0;
      dReady <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (gnt[GNT_I]) begin
            lastGnt <= GNT_I;
            state   <= ARB_BUSY_I;
            cnt     <= LAT_CNT;
          end else if (gnt[GNT_D]) begin
            lastGnt <= GNT_D;
            // Writes complete in the grant cycle; only reads wait on the memory.
            if (bus.d_we) begin
              dReady <= 1'b1;
            end else begin
              state <= ARB_BUSY_D;
              cnt   <= LAT_CNT;
            end
          end
        end
        ARB_BUSY_I: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            iRdata <= bus.mem_rdata;
            iReady <= 1'b1;
            state  <= ARB_IDLE;
          end
        end
        ARB_BUSY_D: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            dRdata <= bus.mem_rdata;
            dReady <= 1'b1;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.mem_en    = |gnt;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.i_ready   = iReady;
  assign bus.d_ready   = dReady;
  assign bus.i_rdata   = iRdata;
  assign bus.d_rdata   = dRdata;
  assign bus.busy      = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 2, 1, 3) each with a small latency-pipelined memory model.
module tb_mem_arbiter;

  logic clk;
  logic rst1, rst2, rst3;
  int   nCmp = 0;
  int   nErr = 0;

  mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) b2 ();
  mem_arbiter_if #(.AW(32), .DW(32)) b3 ();

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) u1 (.clk(clk), .rst(rst1), .bus(b1));
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u2 (.clk(clk), .rst(rst2), .bus(b2));
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u3 (.clk(clk), .rst(rst3), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory models: read data appears MEM_LAT cycles after the strobe.
  logic [31:0] p1 [2];
  logic [31:0] p2;
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    p1[0] <= (b1.mem_en && !b1.mem_we) ? memData(b1.mem_addr) : 32'h0;
    p1[1] <= p1[0];
    p2    <= (b2.mem_en && !b2.mem_we) ? memData(b2.mem_addr) : 32'h0;
    p3[0] <= (b3.mem_en && !b3.mem_we) ? memData(b3.mem_addr) : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.mem_rdata = p1[1];
  assign b2.mem_rdata = p2;
  assign b3.mem_rdata = p3[2];

  // Requesters must hold req until their ready pulse.
  aHoldI1: assert property (@(posedge clk) disable iff (!rst1) (b1.i_req && !b1.i_ready) |=> b1.i_req);
  aHoldD1: assert property (@(posedge clk) disable iff (!rst1) (b1.d_req && !b1.d_ready) |=> b1.d_req);
  aHoldI2: assert property (@(posedge clk) disable iff (!rst2) (b2.i_req && !b2.i_ready) |=> b2.i_req);
  aHoldD2: assert property (@(posedge clk) disable iff (!rst2) (b2.d_req && !b2.d_ready) |=> b2.d_req);
  aHoldI3: assert property (@(posedge clk) disable iff (!rst3) (b3.i_req && !b3.i_ready) |=> b3.i_req);
  aHoldD3: assert property (@(posedge clk) disable iff (!rst3) (b3.d_req && !b3.d_ready) |=> b3.d_req);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit lastPort, port, prevIR, prevDR;
    int grants, lastCyc;

    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    b1.i_req = 0; b1.i_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
    b2.i_req = 0; b2.i_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0;
    b3.i_req = 0; b3.i_addr = 0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   32'(b1.busy), 0);
    chk("rst_iready", 32'(b1.i_ready), 0);
    chk("rst_dready", 32'(b1.d_ready), 0);
    chk("rst_irdata", b1.i_rdata, 0);
    chk("rst_drdata", b1.d_rdata, 0);
    chk("rst_memen",  32'(b1.mem_en), 0);
    nxt(); rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;

    // Single I read, MEM_LAT=2
    nxt(); b1.i_req = 1; b1.i_addr = 32'h100;
    @(negedge clk); chk("t1_en0", 32'(b1.mem_en), 1); chk("t1_addr0", b1.mem_addr, 32'h100);
    chk("t1_we0", 32'(b1.mem_we), 0);
    nxt(); @(negedge clk); chk("t1_en1", 32'(b1.mem_en), 0); chk("t1_busy1", 32'(b1.busy), 1);
    chk("t1_rdy1", 32'(b1.i_ready), 0); chk("t1_addr1", b1.mem_addr, 0);
    nxt(); @(negedge clk); chk("t1_rdy2", 32'(b1.i_ready), 0); chk("t1_en2", 32'(b1.mem_en), 0);
    nxt(); @(negedge clk); chk("t1_rdy3", 32'(b1.i_ready), 1); chk("t1_data3", b1.i_rdata, 32'hDEADBEEF);
    chk("t1_busy3", 32'(b1.busy), 0);
    nxt(); b1.i_req = 0;
    @(negedge clk); chk("t1_rdy4", 32'(b1.i_ready), 0); chk("t1_data4", b1.i_rdata, 32'hDEADBEEF);
    nxt(); @(negedge clk); chk("t1_data5", b1.i_rdata, 32'hDEADBEEF);

    // Reset in BUSY_I with cnt=1, MEM_LAT=2
    nxt(); b1.i_req = 1; b1.i_addr = 32'h200;
    @(negedge clk); chk("t5_en0", 32'(b1.mem_en), 1);
    nxt(); @(negedge clk); chk("t5_busy1", 32'(b1.busy), 1);
    #1 rst1 = 1'b0; b1.i_addr = 32'h300;
    #1 chk("t5_rstbusy", 32'(b1.busy), 0); chk("t5_rstdata", b1.i_rdata, 0);
    chk("t5_rstrdy", 32'(b1.i_ready), 0); chk("t5_rsten", 32'(b1.mem_en), 0);
    nxt(); rst1 = 1'b1;
    @(negedge clk); chk("t5_regrant", 32'(b1.mem_en), 1); chk("t5_readdr", b1.mem_addr, 32'h300);
    chk("t5_rdy2", 32'(b1.i_ready), 0);
    nxt(); @(negedge clk); chk("t5_rdy3", 32'(b1.i_ready), 0); chk("t5_busy3", 32'(b1.busy), 1);
    nxt(); @(negedge clk); chk("t5_rdy4", 32'(b1.i_ready), 0);
    nxt(); @(negedge clk); chk("t5_rdy5", 32'(b1.i_ready), 1); chk("t5_data5", b1.i_rdata, 32'h0300FCFF);
    nxt(); b1.i_req = 0;

    // Simultaneous I/D reads after reset, MEM_LAT=1: D wins first
    nxt(); b2.i_req = 1; b2.i_addr = 32'h500; b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h2000;
    @(negedge clk); chk("t2_en0", 32'(b2.mem_en), 1); chk("t2_addr0", b2.mem_addr, 32'h2000);
    chk("t2_we0", 32'(b2.mem_we), 0);
    nxt(); @(negedge clk); chk("t2_en1", 32'(b2.mem_en), 0); chk("t2_busy1", 32'(b2.busy), 1);
    chk("t2_drdy1", 32'(b2.d_ready), 0);
    nxt(); @(negedge clk); chk("t2_drdy2", 32'(b2.d_ready), 1); chk("t2_ddata2", b2.d_rdata, 32'h2000DFFF);
    chk("t2_en2", 32'(b2.mem_en), 1); chk("t2_addr2", b2.mem_addr, 32'h500);
    nxt(); b2.d_req = 0;
    @(negedge clk); chk("t2_drdy3", 32'(b2.d_ready), 0); chk("t2_irdy3", 32'(b2.i_ready), 0);
    nxt(); @(negedge clk); chk("t2_irdy4", 32'(b2.i_ready), 1); chk("t2_idata4", b2.i_rdata, 32'h0500FAFF);

    // Lone D read to leave last grant = D
    nxt(); b2.i_req = 0; b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h10;
    @(negedge clk); chk("t3_en5", 32'(b2.mem_en), 1); chk("t3_addr5", b2.mem_addr, 32'h10);
    nxt();
    nxt(); @(negedge clk); chk("t3_drdy7", 32'(b2.d_ready), 1); chk("t3_ddata7", b2.d_rdata, 32'h0010FFEF);

    // Continuous I read plus D write, last grant = D: I first, then the write
    nxt(); b2.i_req = 1; b2.i_addr = 32'h600;
    b2.d_req = 1; b2.d_we = 1; b2.d_addr = 32'h40; b2.d_wdata = 32'h12345678;
    @(negedge clk); chk("t3_en8", 32'(b2.mem_en), 1); chk("t3_addr8", b2.mem_addr, 32'h600);
    chk("t3_we8", 32'(b2.mem_we), 0); chk("t3_wd8", b2.mem_wdata, 0);
    nxt(); @(negedge clk); chk("t3_en9", 32'(b2.mem_en), 0); chk("t3_we9", 32'(b2.mem_we), 0);
    nxt(); @(negedge clk); chk("t3_irdy10", 32'(b2.i_ready), 1); chk("t3_en10", 32'(b2.mem_en), 1);
    chk("t3_we10", 32'(b2.mem_we), 1); chk("t3_addr10", b2.mem_addr, 32'h40);
    chk("t3_wd10", b2.mem_wdata, 32'h12345678);
    nxt(); @(negedge clk); chk("t3_drdy11", 32'(b2.d_ready), 1); chk("t3_ddata11", b2.d_rdata, 32'h0010FFEF);
    chk("t3_en11", 32'(b2.mem_en), 1); chk("t3_addr11", b2.mem_addr, 32'h600);
    chk("t3_busy11", 32'(b2.busy), 0);
    nxt(); b2.d_req = 0; b2.d_we = 0;
    @(negedge clk); chk("t3_drdy12", 32'(b2.d_ready), 0); chk("t3_busy12", 32'(b2.busy), 1);
    nxt(); @(negedge clk); chk("t3_irdy13", 32'(b2.i_ready), 1);
    nxt(); b2.i_req = 0;
    @(negedge clk); chk("t3_en14", 32'(b2.mem_en), 0);

    // Both ports continuously requesting, MEM_LAT=3: strict alternation every 4 cycles
    nxt(); b3.i_req = 1; b3.i_addr = 32'h1000; b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h2000;
    grants = 0; lastCyc = 0; lastPort = 0; prevIR = 0; prevDR = 0;
    for (int c = 0; c < 200 && grants < 20; c++) begin
      @(negedge clk);
      if (b3.mem_en) begin
        port = (b3.mem_addr == 32'h2000);
        if (grants == 0) chk("t4_first", 32'(port), 1);
        else begin
          chk("t4_alt", 32'(port), 32'(!lastPort));
          chk("t4_gap", 32'(c - lastCyc), 4);
        end
        lastPort = port; lastCyc = c; grants++;
      end
      if (prevIR) chk("t4_iwidth", 32'(b3.i_ready), 0);
      if (prevDR) chk("t4_dwidth", 32'(b3.d_ready), 0);
      prevIR = b3.i_ready; prevDR = b3.d_ready;
      nxt();
    end
    chk("t4_grants", 32'(grants), 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous unified memory between the pipeline's instruction-fetch port (I) and its MEM-stage data port (D).
- Grants one access at a time and sequences the fixed memory read latency.
- Returns registered data with a one-cycle ready pulse per requester.
- The hazard unit derives stallF/stallD/stallE from req & ~ready on each port.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata. Legal range 1..4.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately)
- i_req  in  1  fetch read request; held until i_ready
- i_addr  in  AW  fetch address; stable while i_req pending
- i_rdata  out  DW  fetch data; registered, held until next I read completes
- i_ready  out  1  one-cycle pulse: I access complete
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1=write, 0=read; stable while pending
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_rdata  out  DW  data read result; registered, held
- d_ready  out  1  one-cycle pulse: D access complete
- mem_en  out  1  memory access strobe; one cycle per access
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after mem_en
- busy  out  1  1 while state != IDLE

Behaviour:
- States: IDLE, BUSY_I, BUSY_D (read only). 3-bit latency counter cnt.
- Eligible requests in IDLE: x_req & ~x_ready. A requester is ignored in the cycle its own ready pulse is high.
- Grant in IDLE (combinational):
  - Only one requester eligible: grant it.
  - Both eligible: grant the one not granted last (last_grant flag). Two-way round robin, so no starvation.
- Grant cycle T:
  - mem_en=1; mem_addr/mem_we/mem_wdata driven from the granted port; last_grant updated at the edge.
  - Outside the grant cycle: mem_en=0, mem_we=0; mem_addr/mem_wdata driven 0.
- I read or D read: state -> BUSY_x with cnt=MEM_LAT-1. Each BUSY cycle with cnt!=0 decrements cnt.
  - In the BUSY cycle with cnt==0, mem_rdata is latched into x_rdata, x_ready is set for one cycle, and state -> IDLE.
  - Read latency: x_ready high in cycle T+MEM_LAT+1.
- D write: state stays IDLE; d_ready pulses in cycle T+1; d_rdata unchanged.
- Throughput:
  - A new grant may be issued in the cycle a ready pulse is high, to the other port only.
  - Back-to-back reads from alternating ports: one per MEM_LAT+1 cycles.
- Requests arriving while BUSY wait; no queueing beyond the held req lines.
- Dropping req before ready is illegal. Behaviour is undefined and must be asserted in the bench.
- Reset (async, any time, including mid-BUSY):
  - state=IDLE, cnt=0, last_grant=I (so D wins the first conflict).
  - i_ready=d_ready=0, i_rdata=d_rdata=0, busy=0.
  - Any in-flight memory response is discarded.
  - The first grant is possible in the first clock cycle after rst deasserts.

Decomposition:
- Shared package: state encoding (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D), grant-select constants (GNT_I=0, GNT_D=1), MEM_LAT_MAX=4.
- One natural sub-module: rr_pick2, a combinational two-way round-robin selector (req[1:0], last -> gnt[1:0]). Instantiated once.

Test Plan:
- MEM_LAT=2, i_req at cycle 0 with i_addr=0x100, memory returns 0xDEADBEEF at cycle 2 -> mem_en only in cycle 0; i_ready=1 in cycle 3 only; i_rdata=0xDEADBEEF held afterwards.
- MEM_LAT=1, i_req and d_req (read 0x2000) both rise at cycle 0 after reset -> D granted cycle 0, d_ready cycle 2; I granted cycle 2, i_ready cycle 4.
- Continuous i_req plus d_req write (0x40 <- 0x12345678) at cycle 0 with last_grant=D -> I granted first; D granted on the next IDLE grant with mem_we=1, mem_wdata=0x12345678; d_ready one cycle later.
- Both ports requesting continuously for 20 grants, MEM_LAT=3 -> grants alternate strictly; every ready pulse is 1 cycle wide; no gap longer than 4 cycles between grants.
- rst driven low in BUSY_I with cnt=1 -> outputs zero asynchronously; the later memory return is ignored; i_ready never pulses for the aborted read; a fresh grant occurs in the first cycle after rst returns high.
